// File: rtl/compress_pkg.sv
// Shared definitions for the compressor word path: bit costs, sequencer states, zzzx code prefix.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package compress_pkg;

  // Compressed size in bits of one word, by comparator outcome
  localparam int CODE_BITS_ZZZZ = 2;
  localparam int CODE_BITS_ZZZX = 12;
  localparam int CODE_BITS_XXXX = 34;

  // Code prefix marking a word whose upper three bytes are zero
  localparam logic [3:0] ZZZX_PREFIX = 4'b1101;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } seq_state_e;

  // Bit cost of one word given the comparator flags
  function automatic logic [5:0] word_cost(input logic match_s, input logic type_matched);
    if (type_matched) begin
      return 6'(CODE_BITS_ZZZZ);
    end
    if (match_s) begin
      return 6'(CODE_BITS_ZZZX);
    end
    return 6'(CODE_BITS_XXXX);
  endfunction

endpackage

// File: rtl/comparator_array1.sv
// Zero-pattern comparator: classifies one word as zzzz, zzzx (low byte only) or unmatched.
// Latency: combinational.
// Backpressure: none; pure function of the word.
module comparator_array1
  import compress_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  output logic [11:0]      code,
  output logic             match_s,
  output logic             type_matched
);

  logic upper_zero;
  logic low_zero;

  assign upper_zero = (word[WIDTH-1:8] == '0);
  assign low_zero   = (word[7:0] == '0);

  // zzzz has an empty code; zzzx carries the prefix plus the surviving low byte
  always_comb begin
    code         = '0;
    match_s      = 1'b0;
    type_matched = 1'b0;
    if (upper_zero && low_zero) begin
      match_s      = 1'b1;
      type_matched = 1'b1;
    end else if (upper_zero) begin
      match_s = 1'b1;
      code    = {ZZZX_PREFIX, word[7:0]};
    end
  end

endmodule

// File: rtl/compress_word_sequencer.sv
// Buffers a cache line and streams it word by word through the zero-pattern comparator.
// Latency: first beat valid the cycle after line acceptance; one beat per cycle; stats one cycle after last beat.
// Backpressure: i_code_ready low holds the current beat; next line accepted on the last-beat handshake.
// Optional line statistics are built when COMP_SEQ_STATS_EN is defined.
module compress_word_sequencer
  import compress_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_WORDS = 4
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_line_valid,
  output logic                               o_line_ready,
  input  logic [NUM_WORDS*WIDTH-1:0]         i_line,
  output logic                               o_code_valid,
  input  logic                               i_code_ready,
  output logic [11:0]                        o_code,
  output logic                               o_match_s,
  output logic                               o_type_matched,
  output logic [WIDTH-1:0]                   o_word,
  output logic [$clog2(NUM_WORDS)-1:0]       o_idx,
  output logic                               o_last,
  output logic                               o_stat_valid,
  output logic [$clog2(NUM_WORDS+1)-1:0]     o_zzzz_cnt,
  output logic [$clog2(NUM_WORDS+1)-1:0]     o_zzzx_cnt,
  output logic [$clog2(34*NUM_WORDS+1)-1:0]  o_line_bits
);

  localparam int IDX_W  = $clog2(NUM_WORDS);
  localparam int CNT_W  = $clog2(NUM_WORDS + 1);
  localparam int BITS_W = $clog2(34 * NUM_WORDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  seq_state_e                 state;
  logic [NUM_WORDS*WIDTH-1:0] line_q;
  logic [IDX_W-1:0]           idx;
  logic [WIDTH-1:0]           cur_word;
  logic [11:0]                cmp_code;
  logic                       cmp_match_s;
  logic                       cmp_type_matched;
  logic                       emit;
  logic                       is_last;
  logic                       beat_fire;
  logic                       last_fire;
  logic                       line_fire;

  assign emit      = (state == EMIT);
  assign is_last   = emit && (idx == LAST_IDX);
  assign cur_word  = line_q[idx*WIDTH +: WIDTH];
  assign beat_fire = emit && i_code_ready;
  assign last_fire = beat_fire && is_last;
  assign line_fire = i_line_valid && o_line_ready;

  comparator_array1 #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .word         (cur_word),
    .code         (cmp_code),
    .match_s      (cmp_match_s),
    .type_matched (cmp_type_matched)
  );

  // Ready in IDLE, or on the final beat so the next line follows without a bubble
  assign o_line_ready = !emit || last_fire;

  // Beat outputs are forced to zero outside EMIT so IDLE presents a clean bus
  assign o_code_valid   = emit;
  assign o_code         = emit ? cmp_code : '0;
  assign o_match_s      = emit && cmp_match_s;
  assign o_type_matched = emit && cmp_type_matched;
  assign o_word         = emit ? cur_word : '0;
  assign o_idx          = emit ? idx : '0;
  assign o_last         = is_last;

  // Line buffer, word index and IDLE/EMIT state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      idx    <= '0;
      line_q <= '0;
    end else if (line_fire) begin
      line_q <= i_line;
      idx    <= '0;
      state  <= EMIT;
    end else if (last_fire) begin
      state <= IDLE;
    end else if (beat_fire) begin
      idx <= idx + 1'b1;
    end
  end

`ifdef COMP_SEQ_STATS_EN
  logic [CNT_W-1:0]  acc_zzzz;
  logic [CNT_W-1:0]  acc_zzzx;
  logic [BITS_W-1:0] acc_bits;
  logic [CNT_W-1:0]  nxt_zzzz;
  logic [CNT_W-1:0]  nxt_zzzx;
  logic [BITS_W-1:0] nxt_bits;
  logic              stat_valid_q;
  logic [CNT_W-1:0]  stat_zzzz_q;
  logic [CNT_W-1:0]  stat_zzzx_q;
  logic [BITS_W-1:0] stat_bits_q;

  // Running totals including the word on the bus this cycle
  always_comb begin
    nxt_zzzz = acc_zzzz + CNT_W'(cmp_type_matched);
    nxt_zzzx = acc_zzzx + CNT_W'(cmp_match_s && !cmp_type_matched);
    nxt_bits = acc_bits + BITS_W'(word_cost(cmp_match_s, cmp_type_matched));
  end

  // Accumulate per beat, publish on the last beat, restart on every new line
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_zzzz     <= '0;
      acc_zzzx     <= '0;
      acc_bits     <= '0;
      stat_valid_q <= 1'b0;
      stat_zzzz_q  <= '0;
      stat_zzzx_q  <= '0;
      stat_bits_q  <= '0;
    end else begin
      stat_valid_q <= last_fire;
      if (last_fire) begin
        stat_zzzz_q <= nxt_zzzz;
        stat_zzzx_q <= nxt_zzzx;
        stat_bits_q <= nxt_bits;
      end
      if (line_fire) begin
        acc_zzzz <= '0;
        acc_zzzx <= '0;
        acc_bits <= '0;
      end else if (beat_fire) begin
        acc_zzzz <= nxt_zzzz;
        acc_zzzx <= nxt_zzzx;
        acc_bits <= nxt_bits;
      end
    end
  end

  assign o_stat_valid = stat_valid_q;
  assign o_zzzz_cnt   = stat_zzzz_q;
  assign o_zzzx_cnt   = stat_zzzx_q;
  assign o_line_bits  = stat_bits_q;
`else
  assign o_stat_valid = 1'b0;
  assign o_zzzz_cnt   = '0;
  assign o_zzzx_cnt   = '0;
  assign o_line_bits  = '0;
`endif

endmodule

// File: tb/tb_compress_word_sequencer.sv
// Self-checking bench for compress_word_sequencer: directed vector table, corner sequences, random traffic.
// Latency: n/a.
// Backpressure: randomised i_code_ready and i_line_valid in the random phase.
module tb_compress_word_sequencer;

  localparam int W  = 32;
  localparam int NW = 4;
  localparam int LW = NW * W;
  localparam int IW = $clog2(NW);
  localparam int CW = $clog2(NW + 1);
  localparam int BW = $clog2(34 * NW + 1);

`ifdef COMP_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk;
  logic          i_reset;
  logic          i_line_valid;
  logic          o_line_ready;
  logic [LW-1:0] i_line;
  logic          o_code_valid;
  logic          i_code_ready;
  logic [11:0]   o_code;
  logic          o_match_s;
  logic          o_type_matched;
  logic [W-1:0]  o_word;
  logic [IW-1:0] o_idx;
  logic          o_last;
  logic          o_stat_valid;
  logic [CW-1:0] o_zzzz_cnt;
  logic [CW-1:0] o_zzzx_cnt;
  logic [BW-1:0] o_line_bits;

  int checks = 0;
  int errors = 0;

  compress_word_sequencer #(
    .WIDTH(W),
    .NUM_WORDS(NW)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_line_valid   (i_line_valid),
    .o_line_ready   (o_line_ready),
    .i_line         (i_line),
    .o_code_valid   (o_code_valid),
    .i_code_ready   (i_code_ready),
    .o_code         (o_code),
    .o_match_s      (o_match_s),
    .o_type_matched (o_type_matched),
    .o_word         (o_word),
    .o_idx          (o_idx),
    .o_last         (o_last),
    .o_stat_valid   (o_stat_valid),
    .o_zzzz_cnt     (o_zzzz_cnt),
    .o_zzzx_cnt     (o_zzzx_cnt),
    .o_line_bits    (o_line_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [11:0]   code;
    logic          ms;
    logic          tm;
    logic [W-1:0]  word;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [CW-1:0] zz;
    logic [CW-1:0] zx;
    logic [BW-1:0] bits;
  } stat_t;

  beat_t exp_beats[$];
  stat_t exp_stats[$];
  stat_t pend;
  logic  stat_due  = 1'b0;
  logic  prev_hold = 1'b0;
  beat_t prev_beat;

  // Expected beats and stats for one line, straight from the word-classification rules
  task automatic model_line(input logic [LW-1:0] line);
    beat_t b;
    stat_t s;
    logic [W-1:0] w;
    int zz = 0;
    int zx = 0;
    int bits = 0;
    for (int k = 0; k < NW; k++) begin
      w      = line[k*W +: W];
      b.word = w;
      b.idx  = IW'(k);
      b.last = (k == NW - 1);
      if (w == 0) begin
        b.code = 12'h000; b.ms = 1'b1; b.tm = 1'b1; zz++; bits += 2;
      end else if (w < 256) begin
        b.code = 12'(32'hD00 + w); b.ms = 1'b1; b.tm = 1'b0; zx++; bits += 12;
      end else begin
        b.code = 12'h000; b.ms = 1'b0; b.tm = 1'b0; bits += 34;
      end
      exp_beats.push_back(b);
    end
    s.zz   = CW'(zz);
    s.zx   = CW'(zx);
    s.bits = BW'(bits);
    exp_stats.push_back(s);
  endtask

  // Monitor: everything sampled mid-cycle, ahead of the edge that acts on it
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur = {o_code, o_match_s, o_type_matched, o_word, o_idx, o_last};
    if (i_reset) begin
      exp_beats.delete();
      exp_stats.delete();
      stat_due  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      check("stat_pulse", 64'(o_stat_valid), 64'(STATS && stat_due));
      if (o_stat_valid || !STATS) begin
        check("stat_zzzz", 64'(o_zzzz_cnt), STATS ? 64'(pend.zz) : 64'd0);
        check("stat_zzzx", 64'(o_zzzx_cnt), STATS ? 64'(pend.zx) : 64'd0);
        check("stat_bits", 64'(o_line_bits), STATS ? 64'(pend.bits) : 64'd0);
      end
      if (prev_hold) begin
        check("hold_valid", 64'(o_code_valid), 64'd1);
        check("hold_data", 64'(cur), 64'(prev_beat));
      end
      stat_due = 1'b0;
      if (o_code_valid && i_code_ready) begin
        check("beat_expected", 64'(exp_beats.size() != 0), 64'd1);
        if (exp_beats.size() != 0) begin
          e = exp_beats.pop_front();
          check("beat", 64'(cur), 64'(e));
          if (e.last && exp_stats.size() != 0) begin
            pend     = exp_stats.pop_front();
            stat_due = 1'b1;
          end
        end
      end
      prev_hold = o_code_valid && !i_code_ready;
      prev_beat = cur;
      if (i_line_valid && o_line_ready) model_line(i_line);
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [LW-1:0] line;
    logic [47:0]   codes;
    logic [3:0]    ms;
    logic [3:0]    tm;
    logic [CW-1:0] zz;
    logic [CW-1:0] zx;
    logic [BW-1:0] bits;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v);
    logic [LW-1:0] l;
    logic [47:0]   c;
    l = v.line;
    c = v.codes;
    i_line       = v.line;
    i_line_valid = 1'b1;
    i_code_ready = 1'b1;
    check("vec_line_ready", 64'(o_line_ready), 64'd1);
    tick();
    i_line_valid = 1'b0;
    for (int k = 0; k < NW; k++) begin
      check("vec_valid", 64'(o_code_valid), 64'd1);
      check("vec_idx", 64'(o_idx), 64'(k));
      check("vec_code", 64'(o_code), 64'(c[k*12 +: 12]));
      check("vec_match_s", 64'(o_match_s), 64'(v.ms[k]));
      check("vec_type", 64'(o_type_matched), 64'(v.tm[k]));
      check("vec_last", 64'(o_last), 64'(k == NW - 1));
      check("vec_word", 64'(o_word), 64'(l[k*W +: W]));
      tick();
    end
    check("vec_done_valid", 64'(o_code_valid), 64'd0);
    check("vec_stat_valid", 64'(o_stat_valid), 64'(STATS));
    check("vec_zzzz", 64'(o_zzzz_cnt), STATS ? 64'(v.zz) : 64'd0);
    check("vec_zzzx", 64'(o_zzzx_cnt), STATS ? 64'(v.zx) : 64'd0);
    check("vec_bits", 64'(o_line_bits), STATS ? 64'(v.bits) : 64'd0);
    tick();
    check("vec_stat_once", 64'(o_stat_valid), 64'd0);
    check("vec_stat_hold", 64'(o_line_bits), STATS ? 64'(v.bits) : 64'd0);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    logic [W-1:0]  w;
    l = '0;
    for (int k = 0; k < NW; k++) begin
      case ($urandom_range(0, 2))
        0:       w = '0;
        1:       w = W'($urandom_range(1, 255));
        default: w = $urandom | 32'h0000_0100;
      endcase
      l[k*W +: W] = w;
    end
    return l;
  endfunction

  localparam logic [LW-1:0] MIXED = 128'h00000001_12345678_000000AB_00000000;

  initial begin
    logic [11:0]   held_code;
    logic [LW-1:0] line_b;
    int cyc;
    int stall_left;
    int pulses;
    bit done;

    vecs[0] = '{line: '0, codes: 48'h000_000_000_000, ms: 4'b1111, tm: 4'b1111,
                zz: 3'd4, zx: 3'd0, bits: 8'd8};
    vecs[1] = '{line: MIXED, codes: 48'hD01_000_DAB_000, ms: 4'b1011, tm: 4'b0001,
                zz: 3'd1, zx: 3'd2, bits: 8'd60};
    vecs[2] = '{line: 128'h01000000_80000000_00000100_FFFFFFFF, codes: 48'h0,
                ms: 4'b0000, tm: 4'b0000, zz: 3'd0, zx: 3'd0, bits: 8'd136};
    vecs[3] = '{line: 128'h0000005A_00000080_00000001_000000FF, codes: 48'hD5A_D80_D01_DFF,
                ms: 4'b1111, tm: 4'b0000, zz: 3'd0, zx: 3'd4, bits: 8'd48};

    i_reset      = 1'b1;
    i_line_valid = 1'b0;
    i_code_ready = 1'b0;
    i_line       = '0;
    tick(); tick(); tick();

    // reset state
    check("rst_line_ready", 64'(o_line_ready), 64'd1);
    check("rst_code_valid", 64'(o_code_valid), 64'd0);
    check("rst_last", 64'(o_last), 64'd0);
    check("rst_stat_valid", 64'(o_stat_valid), 64'd0);
    check("rst_beat", 64'({o_code, o_match_s, o_type_matched, o_word, o_idx}), 64'd0);
    check("rst_stats", 64'({o_zzzz_cnt, o_zzzx_cnt, o_line_bits}), 64'd0);
    i_reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // backpressure: three stalled cycles on beat 1
    i_line       = MIXED;
    i_line_valid = 1'b1;
    i_code_ready = 1'b1;
    tick();
    i_line_valid = 1'b0;
    cyc        = 1;
    stall_left = 3;
    done       = 1'b0;
    held_code  = '0;
    while (!done && cyc < 40) begin
      if (o_code_valid && o_idx == 1 && stall_left > 0) begin
        i_code_ready = 1'b0;
        if (stall_left < 3) begin
          check("bp_idx", 64'(o_idx), 64'd1);
          check("bp_code", 64'(o_code), 64'(held_code));
        end else begin
          held_code = o_code;
        end
        stall_left--;
      end else begin
        i_code_ready = 1'b1;
      end
      if (o_code_valid && o_last && i_code_ready) done = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    check("bp_held_code", 64'(held_code), 64'hDAB);
    check("bp_completion_cycle", 64'(cyc), 64'(NW + 3));
    tick(); tick();

    // back-to-back lines with i_line_valid held
    line_b       = 128'h00000000_00000077_DEADBEEF_00000000;
    i_line       = MIXED;
    i_line_valid = 1'b1;
    i_code_ready = 1'b1;
    tick();
    i_line = line_b;
    pulses = 0;
    for (int k = 1; k < NW; k++) tick();
    check("b2b_last", 64'(o_last), 64'd1);
    check("b2b_ready", 64'(o_line_ready), 64'd1);
    tick();
    i_line_valid = 1'b0;
    check("b2b_no_bubble", 64'(o_code_valid), 64'd1);
    check("b2b_idx0", 64'(o_idx), 64'd0);
    check("b2b_word0", 64'(o_word), 64'd0);
    for (int k = 0; k < NW + 3; k++) begin
      if (o_stat_valid) pulses++;
      tick();
    end
    check("b2b_stat_pulses", 64'(pulses), STATS ? 64'd2 : 64'd0);

    // reset in the middle of a line
    i_line       = MIXED;
    i_line_valid = 1'b1;
    tick();
    i_line_valid = 1'b0;
    tick(); tick();
    check("mid_rst_at_beat2", 64'(o_idx), 64'd2);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("mid_rst_valid", 64'(o_code_valid), 64'd0);
    check("mid_rst_ready", 64'(o_line_ready), 64'd1);
    check("mid_rst_stat", 64'(o_stat_valid), 64'd0);
    tick();
    check("mid_rst_no_pulse", 64'(o_stat_valid), 64'd0);
    check("mid_rst_idle", 64'(o_code_valid), 64'd0);
    run_vec(vecs[1]);

    // random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      i_line       = rand_line();
      i_line_valid = ($urandom_range(0, 3) != 0);
      i_code_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    i_line_valid = 1'b0;
    i_code_ready = 1'b1;
    for (int n = 0; n < 2 * NW + 4; n++) tick();
    check("drain_empty", 64'(exp_beats.size()), 64'd0);
    check("drain_idle", 64'(o_code_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
